// File: rtl/inert_sensor_serf_if.sv
// SPI link between the yaw-rate monarch and the inertial-sensor serf.
// The master modport is the monarch side, the slave modport is the serf.
interface inert_sensor_serf_if;
  logic SS_n;   // serf select, active low
  logic SCLK;   // SPI clock, idles high
  logic MOSI;   // monarch to serf data
  logic MISO;   // serf to monarch data
  logic INT;    // new-measurement flag

  modport master (
    output SS_n,
    output SCLK,
    output MOSI,
    input  MISO,
    input  INT
  );

  modport slave (
    input  SS_n,
    input  SCLK,
    input  MOSI,
    output MISO,
    output INT
  );
endinterface

// File: rtl/inert_sensor_serf.sv
// SPI serf model of the 6-axis inertial sensor, answering the Z-gyro
// yaw-rate monarch. Holds three config registers, samples yaw_in every
// ODR_CYCLES clocks once enabled, and flags fresh data on INT.
// Optional build macro: INERT_SERF_NOISE_EN adds LFSR noise (-8..+7) to
// each latched yaw sample.
module inert_sensor_serf #(
  parameter logic [15:0] ODR_CYCLES = 16'd2048,
  parameter logic [7:0]  WHO_AM_I   = 8'h6A
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inert_sensor_serf_if.slave   spi,
  input  logic [15:0]          yaw_in,
  output logic                 cfg_done
);

  localparam logic [6:0] ADDR_CTRL   = 7'h0D;
  localparam logic [6:0] ADDR_WHOAMI = 7'h0F;
  localparam logic [6:0] ADDR_ODR    = 7'h11;
  localparam logic [6:0] ADDR_MISC   = 7'h14;
  localparam logic [6:0] ADDR_YAW_L  = 7'h26;
  localparam logic [6:0] ADDR_YAW_H  = 7'h27;

  // ---------------------------------------------------------------------
  // Input synchronizers: [0],[1] are the 2-flop synchronizer, [2] is the
  // edge-detect flop. Select and clock reset to their idle-high level so
  // reset release never fakes an edge.
  // ---------------------------------------------------------------------
  logic [2:0] ss_sync;
  logic [2:0] sclk_sync;
  logic [2:0] mosi_sync;

  // Shift each asynchronous SPI input through its synchronizer chain.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync   <= 3'b111;
      sclk_sync <= 3'b111;
      mosi_sync <= 3'b000;
    end else begin
      ss_sync   <= {ss_sync[1:0],   spi.SS_n};
      sclk_sync <= {sclk_sync[1:0], spi.SCLK};
      mosi_sync <= {mosi_sync[1:0], spi.MOSI};
    end
  end

  logic ss_fall;
  logic ss_rise;
  logic ss_active;
  logic sclk_rise;
  logic sclk_fall;
  logic mosi_bit;

  assign ss_fall   = ~ss_sync[1] &  ss_sync[2];
  assign ss_rise   =  ss_sync[1] & ~ss_sync[2];
  assign ss_active = ~ss_sync[1];
  assign sclk_rise =  sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] &  sclk_sync[2];
  assign mosi_bit  =  mosi_sync[2];

  // ---------------------------------------------------------------------
  // Frame shifter
  // ---------------------------------------------------------------------
  logic [15:0] rx_shft;
  logic [7:0]  tx_shft;
  logic [4:0]  bit_cnt;
  logic [15:0] rx_next;
  logic        shift_en;
  logic        rd_load;
  logic [6:0]  rd_addr;
  logic [7:0]  rd_data;

  // Config registers and sampled data (declared here for the read mux).
  logic [7:0]  reg_ctrl;
  logic [7:0]  reg_odr;
  logic [7:0]  reg_misc;
  logic [7:0]  yaw_l;
  logic [7:0]  yaw_h;
  logic [7:0]  yaw_h_shadow;

  assign rx_next  = {rx_shft[14:0], mosi_bit};
  assign shift_en = sclk_rise & ss_active;
  // Command byte is complete on the 8th rising edge; a read preloads the
  // reply in that same cycle so it is on MISO before the next falling edge.
  assign rd_load  = shift_en & (bit_cnt == 5'd7) & rx_next[7];
  assign rd_addr  = rx_next[6:0];

  // Read mux for the address carried in the command byte being completed.
  // NOTE: always_comb assigns a default first so no path leaves rd_data
  // unassigned and infers a latch.
  always_comb begin
    rd_data = 8'h00;
    unique case (rd_addr)
      ADDR_CTRL:   rd_data = reg_ctrl;
      ADDR_WHOAMI: rd_data = WHO_AM_I;
      ADDR_ODR:    rd_data = reg_odr;
      ADDR_MISC:   rd_data = reg_misc;
      ADDR_YAW_L:  rd_data = yaw_l;
      ADDR_YAW_H:  rd_data = yaw_h_shadow;
      default:     rd_data = 8'h00;
    endcase
  end

  // Receive shift, bit counting, reply preload and reply shift-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shft <= 16'h0000;
      tx_shft <= 8'h00;
      bit_cnt <= 5'd0;
    end else if (ss_fall) begin
      tx_shft <= 8'h00;
      bit_cnt <= 5'd0;
    end else if (shift_en) begin
      rx_shft <= rx_next;
      if (bit_cnt != 5'd16) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (rd_load) begin
        tx_shft <= rd_data;
      end
    end else if (sclk_fall && (bit_cnt >= 5'd9) && (bit_cnt <= 5'd15)) begin
      tx_shft <= {tx_shft[6:0], 1'b0};
    end
  end

  assign spi.MISO = (bit_cnt >= 5'd8) ? tx_shft[7] : 1'b0;

  // ---------------------------------------------------------------------
  // Frame completion decode
  // ---------------------------------------------------------------------
  logic       frame_done;
  logic       wr_ctrl;
  logic       wr_odr;
  logic       wr_misc;
  logic       rd_yaw_h_done;
  logic [6:0] frame_addr;

  assign frame_addr    = rx_shft[14:8];
  assign frame_done    = ss_rise & (bit_cnt == 5'd16);
  assign wr_ctrl       = frame_done & ~rx_shft[15] & (frame_addr == ADDR_CTRL);
  assign wr_odr        = frame_done & ~rx_shft[15] & (frame_addr == ADDR_ODR);
  assign wr_misc       = frame_done & ~rx_shft[15] & (frame_addr == ADDR_MISC);
  assign rd_yaw_h_done = frame_done &  rx_shft[15] & (frame_addr == ADDR_YAW_H);

  // ---------------------------------------------------------------------
  // Config register file and cfg_done tracking
  // ---------------------------------------------------------------------
  logic seen_ctrl;
  logic seen_odr;
  logic seen_misc;

  // Store config writes and raise cfg_done with the last of the three.
  // NOTE: the register file is small and architecturally visible after
  // reset, so every entry gets an explicit reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_ctrl  <= 8'h00;
      reg_odr   <= 8'h00;
      reg_misc  <= 8'h00;
      seen_ctrl <= 1'b0;
      seen_odr  <= 1'b0;
      seen_misc <= 1'b0;
      cfg_done  <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        reg_ctrl  <= rx_shft[7:0];
        seen_ctrl <= 1'b1;
      end
      if (wr_odr) begin
        reg_odr  <= rx_shft[7:0];
        seen_odr <= 1'b1;
      end
      if (wr_misc) begin
        reg_misc  <= rx_shft[7:0];
        seen_misc <= 1'b1;
      end
      if ((seen_ctrl | wr_ctrl) & (seen_odr | wr_odr) & (seen_misc | wr_misc)) begin
        cfg_done <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output-data-rate timer and sampling
  // ---------------------------------------------------------------------
  logic        sample_en;
  logic [15:0] odr_timer;
  logic        tick;
  logic [15:0] yaw_sample;
  logic        int_flag;

  assign sample_en = reg_ctrl[1] & (reg_odr != 8'h00);
  assign tick      = sample_en & (odr_timer == (ODR_CYCLES - 16'd1));

`ifdef INERT_SERF_NOISE_EN
  logic [7:0] lfsr;

  // Maximal 8-bit LFSR (x^8+x^6+x^5+x^4+1), stepped once per sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else if (tick) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign yaw_sample = yaw_in + {{12{lfsr[3]}}, lfsr[3:0]};
`else
  assign yaw_sample = yaw_in;
`endif

  // Free-running sample period counter, parked at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      odr_timer <= 16'h0000;
    end else if (!sample_en || tick) begin
      odr_timer <= 16'h0000;
    end else begin
      odr_timer <= odr_timer + 16'd1;
    end
  end

  // Latch yaw on each tick; overrun simply overwrites the previous sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yaw_l <= 8'h00;
      yaw_h <= 8'h00;
    end else if (tick) begin
      {yaw_h, yaw_l} <= yaw_sample;
    end
  end

  // Snapshot the high byte when the low byte is fetched so a later high
  // byte read pairs with it even if a new sample lands in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yaw_h_shadow <= 8'h00;
    end else if (rd_load && (rd_addr == ADDR_YAW_L)) begin
      yaw_h_shadow <= yaw_h;
    end
  end

  // INT: set by a tick, cleared by a completed high-byte read; a tick in
  // the same cycle as the clearing read keeps INT set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_flag <= 1'b0;
    end else if (!sample_en) begin
      int_flag <= 1'b0;
    end else if (tick) begin
      int_flag <= 1'b1;
    end else if (rd_yaw_h_done) begin
      int_flag <= 1'b0;
    end
  end

  assign spi.INT = int_flag;

endmodule

// File: tb/tb_inert_sensor_serf.sv
// Directed bench for inert_sensor_serf: acts as the SPI monarch (mode 3,
// MSB first, 16-bit frames) and checks replies, INT and cfg_done.
module tb_inert_sensor_serf;

  localparam logic [15:0] ODR = 16'd1000;
  localparam int          H   = 10;   // SCLK half period in clk cycles

  logic        clk;
  logic        rst_n;
  logic [15:0] yaw_in;
  logic        cfg_done;
  int          cyc;
  int          n_cmp;
  int          n_bad;

  inert_sensor_serf_if spi ();

  inert_sensor_serf #(
    .ODR_CYCLES (ODR),
    .WHO_AM_I   (8'h6A)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .spi      (spi.slave),
    .yaw_in   (yaw_in),
    .cfg_done (cfg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cmp8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic cmp1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Shift the first nbits of cmd while SS_n is already low; returns the
  // bits seen on MISO just before rising edges 9..16.
  task automatic spi_bits(input logic [15:0] cmd, input int nbits, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi.SCLK = 1'b0;
      spi.MOSI = cmd[15-i];
      wait_clk(H);
      if (i >= 8) rd = {rd[6:0], spi.MISO};
      spi.SCLK = 1'b1;
      wait_clk(H);
    end
  endtask

  task automatic spi_frame(input logic [15:0] cmd, input int nbits, output logic [7:0] rd);
    spi.SS_n = 1'b0;
    wait_clk(H);
    spi_bits(cmd, nbits, rd);
    spi.SS_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic wait_int_rise(input string name);
    logic prev;
    logic seen;
    prev = spi.INT;
    seen = 1'b0;
    for (int i = 0; i < int'(ODR) + 100 && !seen; i++) begin
      @(negedge clk);
      if (spi.INT && !prev) seen = 1'b1;
      prev = spi.INT;
    end
    cmp1(name, seen, 1'b1);
  endtask

  task automatic test_reset;
    cmp1("reset_miso", spi.MISO, 1'b0);
    cmp1("reset_int", spi.INT, 1'b0);
    cmp1("reset_cfg_done", cfg_done, 1'b0);
  endtask

  task automatic test_who_am_i;
    logic [7:0] rd;
    spi_frame(16'h8F00, 16, rd);
    cmp8("who_am_i", rd, 8'h6A);
    cmp1("who_int", spi.INT, 1'b0);
    cmp1("who_cfg_done", cfg_done, 1'b0);
  endtask

  task automatic test_config;
    logic [7:0] rd;
    int t0;
    spi_frame(16'h0D02, 16, rd);
    cmp1("cfg_after_0d", cfg_done, 1'b0);
    spi_frame(16'h1160, 16, rd);
    t0 = cyc;
    cmp1("cfg_after_11", cfg_done, 1'b0);
    spi_frame(16'h1440, 16, rd);
    cmp1("cfg_after_14", cfg_done, 1'b1);
    while (cyc < t0 + int'(ODR) - 12) @(negedge clk);
    cmp1("int_before_odr", spi.INT, 1'b0);
    while (cyc < t0 + int'(ODR) + 8) @(negedge clk);
    cmp1("int_after_odr", spi.INT, 1'b1);
    spi_frame(16'h8D00, 16, rd);
    cmp8("rd_0d", rd, 8'h02);
    spi_frame(16'h9100, 16, rd);
    cmp8("rd_11", rd, 8'h60);
    spi_frame(16'h9400, 16, rd);
    cmp8("rd_14", rd, 8'h40);
  endtask

  task automatic test_yaw_read;
    logic [7:0] rd;
    // High byte without a prior low-byte read returns the reset shadow.
    spi_frame(16'hA700, 16, rd);
    cmp8("shadow_initial", rd, 8'h00);
    wait_int_rise("int_rise_yaw");
    spi_frame(16'hA600, 16, rd);
    cmp8("yaw_l_1234", rd, 8'h34);
    yaw_in = 16'hABCD;
    wait_clk(int'(ODR));          // one tick latches ABCD between the reads
    cmp1("int_before_h_read", spi.INT, 1'b1);
    spi_frame(16'hA700, 16, rd);
    cmp8("yaw_h_torn", rd, 8'h12);
    cmp1("int_cleared", spi.INT, 1'b0);
    spi_frame(16'hA600, 16, rd);
    cmp8("yaw_l_abcd", rd, 8'hCD);
    spi_frame(16'hA700, 16, rd);
    cmp8("yaw_h_abcd", rd, 8'hAB);
  endtask

  task automatic test_abort;
    logic [7:0] rd;
    wait_int_rise("int_rise_abort");
    spi_frame(16'h1100, 10, rd);
    cmp1("abort_int_kept", spi.INT, 1'b1);
    spi_frame(16'h9100, 16, rd);
    cmp8("abort_reg11", rd, 8'h60);
    cmp1("abort_int_still", spi.INT, 1'b1);
    spi_frame(16'hA700, 16, rd);
    cmp1("abort_int_cleared", spi.INT, 1'b0);
    wait_int_rise("abort_still_enabled");
  endtask

  task automatic test_overrun;
    logic [7:0] rd;
    yaw_in = 16'h0001;
    wait_clk(int'(ODR) + 10);
    yaw_in = 16'h0002;
    wait_clk(int'(ODR));
    cmp1("overrun_int", spi.INT, 1'b1);
    spi_frame(16'hA600, 16, rd);
    cmp8("overrun_l", rd, 8'h02);
    spi_frame(16'hA700, 16, rd);
    cmp8("overrun_h", rd, 8'h00);
    cmp1("overrun_int_clr", spi.INT, 1'b0);
  endtask

  task automatic test_simultaneous;
    logic [7:0] rd;
    logic       dropped;
    int         c;
    wait_int_rise("int_rise_simul");
    c = cyc;                      // the tick edge that set INT
    yaw_in = 16'h5A5A;
    spi.SS_n = 1'b0;
    wait_clk(H);
    spi_bits(16'hA700, 16, rd);
    // SS_n rise is seen three edges later, landing on the next tick edge.
    while (cyc < c + int'(ODR) - 3) @(negedge clk);
    spi.SS_n = 1'b1;
    dropped = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!spi.INT) dropped = 1'b1;
    end
    cmp8("simul_h_read", rd, 8'h00);
    cmp1("simul_int_dropped", dropped, 1'b0);
    spi_frame(16'hA600, 16, rd);
    cmp8("simul_new_l", rd, 8'h5A);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] rd;
    cmp1("pre_reset_cfg", cfg_done, 1'b1);
    spi.SS_n = 1'b0;
    wait_clk(H);
    spi_bits(16'h8F00, 12, rd);
    spi.SCLK = 1'b0;
    wait_clk(H);
    cmp1("mid_frame_miso", spi.MISO, 1'b1);
    rst_n = 1'b0;
    wait_clk(2);
    cmp1("mid_reset_miso", spi.MISO, 1'b0);
    cmp1("mid_reset_int", spi.INT, 1'b0);
    cmp1("mid_reset_cfg", cfg_done, 1'b0);
    spi.SS_n = 1'b1;
    spi.SCLK = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    spi_frame(16'h8F00, 16, rd);
    cmp8("post_reset_who", rd, 8'h6A);
    spi_frame(16'h9100, 16, rd);
    cmp8("post_reset_reg11", rd, 8'h00);
    cmp1("post_reset_int", spi.INT, 1'b0);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    spi.SS_n = 1'b1;
    spi.SCLK = 1'b1;
    spi.MOSI = 1'b0;
    yaw_in   = 16'h1234;
    wait_clk(5);
    test_reset;
    rst_n = 1'b1;
    wait_clk(5);
    test_who_am_i;
    test_config;
    test_yaw_read;
    test_abort;
    test_overrun;
    test_simultaneous;
    test_reset_mid_frame;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inert_sensor_serf.md
Name: inert_sensor_serf

Overview:
- Synthesizable SPI serf model of the ST 6-axis inertial sensor.
- The Z-gyro yaw-rate interface module is the SPI monarch; this block answers it in bench and FPGA loop-back.
- Holds a small config register file and samples an externally supplied yaw rate at a fixed output data rate.
- Raises INT when a fresh sample is ready and clears it when the yaw high byte is read.

Parameters:
- ODR_CYCLES, 16'd2048, clk cycles between yaw samples (sample period).
- WHO_AM_I, 8'h6A, value returned on read of address 0x0F.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- SS_n  input  1  SPI serf select, active low
- SCLK  input  1  SPI clock, idles high
- MOSI  input  1  SPI data from monarch
- MISO  output  1  SPI data to monarch
- INT  output  1  new-measurement flag
- yaw_in  input  16  signed yaw rate to be reported
- cfg_done  output  1  high once registers 0x0D, 0x11 and 0x14 have each been written

Behaviour:
- Reset values: MISO=0, INT=0, cfg_done=0; all registers, yaw_L, yaw_H, H-shadow, bit_cnt and ODR timer = 0.
- Input sync: SS_n, SCLK and MOSI each pass through a 2-flop synchronizer plus one edge-detect flop. SCLK rise/fall and SS_n fall/rise are single-clk pulses.
- SCLK high time is at least 8 clk, which gives ≥4 clk of margin over the sync latency.
- Frame: 16 bits, MSB first. Bit15 = R/W̄ (1 = read). Bits14:8 = 7-bit address. Bits7:0 = write data, or don't-care on read.
- SS_n fall: clear bit_cnt and tx_shft. MISO = 0 during the command byte.
- SCLK rise while SS_n low: shift MOSI into rx_shft[15:0] (LSB in) and increment bit_cnt. bit_cnt saturates at 16.
- When bit_cnt becomes 8 and rx_shft[7]=1: load tx_shft[7:0] with the read mux value for address rx_shft[6:0].
- SCLK fall with bit_cnt in 9..15: shift tx_shft left. MISO = tx_shft[7] whenever bit_cnt ≥ 8.
- Read mux:
  - 0x0D, 0x11, 0x14 → stored register value
  - 0x0F → WHO_AM_I
  - 0x26 → yaw_L
  - 0x27 → H-shadow
  - all other addresses → 8'h00
- Torn-read protection: the H-shadow is loaded from yaw_H in the same cycle the 0x26 read byte is loaded. A read of 0x27 without a preceding 0x26 read returns the shadow as last loaded.
- SS_n rise with bit_cnt==16 completes the frame. Write to address 0x0D/0x11/0x14 stores rx_shft[7:0]. Writes to any other address are ignored.
- SS_n rise with bit_cnt≠16 aborts the frame: no write, no INT clear, no state change.
- cfg_done is set on completion of the last of the three config writes. It is sticky until reset.
- Sampling is enabled when reg0x0D[1]=1 and reg0x11≠0.
- While disabled, the ODR timer is held at 0 and INT is forced to 0.
- While enabled, the ODR timer counts 0..ODR_CYCLES-1. On wrap (sample tick) yaw_in is latched into {yaw_H,yaw_L} and INT is set.
- INT clears on completion of a read frame to address 0x27.
- Sample tick in the same cycle as a 0x27 completion: the tick wins, INT stays 1, and new data is latched.
- Overrun: a tick while INT=1 overwrites the yaw regs and INT stays 1.
- Reset mid-frame returns everything to reset values. A partial frame after reset is discarded because bit_cnt≠16.

Optional Feature:
- Macro: INERT_SERF_NOISE_EN.
- Defined: an 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset) advances once per sample tick. Its value sign-extended from bits[3:0] (range −8..+7) is added to yaw_in before latching; the 16-bit add wraps.
- Not defined: yaw_in is latched unmodified and no LFSR exists.

Test Plan:
- Read 0x8F00 after reset → second byte on MISO = 8'h6A; INT stays 0; cfg_done=0.
- Write frames 0x0D02, 0x1160, 0x1440 → cfg_done rises after the third SS_n rise; readback 0x8D00/0x9100/0x9400 returns 02/60/40; INT rises ODR_CYCLES clk after the 0x1160 write.
- yaw_in=16'h1234, wait for INT, read 0xA600 then 0xA700 → returns 34 then 12; INT falls within 4 clk of the second SS_n rise. Change yaw_in to 16'hABCD and force a tick between the two reads → H read still returns 12.
- Abort: drop SS_n, clock 10 bits of 0x1100, raise SS_n → reg0x11 unchanged, sampling still enabled; INT=1 remains set if it was set.
- Overrun/simultaneity: leave INT unread across two ticks with yaw_in 0x0001 then 0x0002 → read returns 0x0002. Align 0x27 completion with a tick → INT stays 1.
- Assert rst_n low mid-read after bit 12 → MISO=0, INT=0, cfg_done=0; the next full 0x8F00 read returns 6A.
